// File: rtl/aes_pkg.sv
// Shared AES-128 constants and types for the inverse key schedule and its g() helper.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] key_t;

  localparam logic [7:0] RCON [NUM_ROUNDS] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {IDLE, EMIT, DONE} inv_ks_state_t;

endpackage

// File: rtl/g_func_key_expansion.sv
// AES key-expansion g(): RotWord, SubWord and round-constant XOR on one 32-bit word.
module g_func_key_expansion
  import aes_pkg::*;
(
  input  word_t      input_word,
  input  logic [3:0] count,
  output word_t      g_word
);

  // Forward S-box, byte 0x00 in the most significant position.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [2047:0] sh;
    sh = SBOX << {b, 3'b000};
    return sh[2047:2040];
  endfunction

  logic [7:0] rc;

  // count only ranges 0..9 when the result is used; anything else yields a zero constant.
  always_comb begin
    rc = 8'h00;
    if (count < 4'd10) rc = RCON[count];
  end

  assign g_word = {sbox(input_word[23:16]) ^ rc, sbox(input_word[15:8]),
                   sbox(input_word[7:0]), sbox(input_word[31:24])};

endmodule

// File: rtl/inv_key_schedule.sv
// Walks the AES-128 key expansion backwards from the round-10 key, emitting keys 10 down to 0.
module inv_key_schedule
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] last_key,
  input  logic         key_ready,
  output logic         key_valid,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done
);

  inv_ks_state_t state;
  key_t          key_reg;
  logic [3:0]    cnt;
  logic [3:0]    cnt_m1;
  word_t         w0, w1, w2, w3;
  word_t         p0, p1, p2, p3;
  word_t         g_out;
  key_t          prev_key;

  assign {w0, w1, w2, w3} = key_reg;
  assign cnt_m1 = cnt - 4'd1;

  // Undo one expansion step: later words recover earlier ones by pairwise XOR, w0 needs g().
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;
  assign p0 = w0 ^ g_out;
  assign prev_key = {p0, p1, p2, p3};

  g_func_key_expansion u_g_func (
    .input_word (p3),
    .count      (cnt_m1),
    .g_word     (g_out)
  );

  // Handshake: a beat transfers on a rising edge where key_valid && key_ready; while
  // key_valid is high and key_ready is low, round_key and round_idx hold unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      key_reg   <= '0;
      cnt       <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            key_reg   <= last_key;
            cnt       <= 4'(NUM_ROUNDS);
            key_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (key_valid && key_ready) begin
            if (cnt != 4'd0) begin
              key_reg <= prev_key;
              cnt     <= cnt_m1;
            end else begin
              key_valid <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign round_key = key_reg;
  assign round_idx = cnt;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Bench for inv_key_schedule: directed FIPS-197 cases plus random keys against a forward-expansion model.
module tb_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] last_key;
  logic         key_ready;
  logic         key_valid;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;

  int tests = 0;
  int fails = 0;

  logic [7:0]   sb [256];
  logic [127:0] rk [11];
  logic [127:0] got [11];
  logic [131:0] exp_q [$];

  inv_key_schedule dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .last_key  (last_key),
    .key_ready (key_ready),
    .key_valid (key_valid),
    .round_key (round_key),
    .round_idx (round_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]] ^ rc, sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic load_q();
    exp_q.delete();
    for (int r = 10; r >= 0; r--) exp_q.push_back({4'(r), rk[r]});
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic start_key(input logic [127:0] k);
    last_key = k;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Consumes the expected stream; optionally stalls, injects a stray start, aborts with rst,
  // or randomizes key_ready.
  task automatic drain(input int stall_at, input int inject_at, input logic [127:0] other,
                       input int abort_at, input bit rnd_ready);
    logic [131:0] e;
    int           guard, stalls, eidx;
    bit           injected, aborted;
    guard = 0; stalls = 0; injected = 0; aborted = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      e = exp_q[0];
      eidx = int'(e[131:128]);
      start = 1'b0;
      key_ready = 1'b1;
      check("valid", 128'(key_valid), 128'd1);
      check("idx", 128'(round_idx), 128'(e[131:128]));
      check("key", round_key, e[127:0]);
      if (eidx == abort_at) begin
        rst = 1'b1;
        aborted = 1;
      end else begin
        if (eidx == stall_at && stalls < 3) begin
          key_ready = 1'b0;
          stalls++;
        end else if (rnd_ready) begin
          key_ready = 1'($urandom_range(0, 1));
        end
        if (eidx == inject_at && !injected) begin
          start = 1'b1;
          last_key = other;
          injected = 1;
        end
        if (key_ready) begin
          got[e[131:128]] = round_key;
          void'(exp_q.pop_front());
        end
      end
      @(posedge clk); #1;
      guard++;
      if (aborted) begin
        rst = 1'b0;
        break;
      end
    end
    start = 1'b0;
    key_ready = 1'b1;
    check("drain_timeout", 128'(guard >= 200), 128'd0);
    if (aborted) begin
      check("rst_valid", 128'(key_valid), 128'd0);
      check("rst_key", round_key, 128'd0);
      check("rst_idx", 128'(round_idx), 128'd0);
      check("rst_busy", 128'(busy), 128'd0);
      check("rst_done", 128'(done), 128'd0);
      @(posedge clk); #1;
      check("rst_no_done", 128'(done), 128'd0);
      check("rst_idle_valid", 128'(key_valid), 128'd0);
    end
  endtask

  // Called one step after the idx0 beat is accepted: the done cycle.
  task automatic finish_check(input bit start_in_done, input logic [127:0] other);
    check("done_pulse", 128'(done), 128'd1);
    check("done_valid", 128'(key_valid), 128'd0);
    check("done_busy", 128'(busy), 128'd1);
    if (start_in_done) begin
      start = 1'b1;
      last_key = other;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("idle_done", 128'(done), 128'd0);
    check("idle_busy", 128'(busy), 128'd0);
    check("idle_valid", 128'(key_valid), 128'd0);
  endtask

  initial begin
    logic [127:0] k;
    rst = 1'b1;
    start = 1'b0;
    key_ready = 1'b0;
    last_key = '0;
    build_sbox();
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 128'(key_valid), 128'd0);
    check("reset_key", round_key, 128'd0);
    check("reset_idx", 128'(round_idx), 128'd0);
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_done", 128'(done), 128'd0);
    rst = 1'b0;
    key_ready = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 Appendix A key at full rate
    expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    load_q();
    start_key(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    drain(-1, -1, '0, -1, 1'b0);
    finish_check(1'b0, '0);
    check("fips_idx10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("fips_idx9", got[9], 128'hac7766f319fadc2128d12941575c006e);
    check("fips_idx1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("fips_idx0", got[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

    // Backpressure at idx 5
    load_q();
    start_key(rk[10]);
    drain(5, -1, '0, -1, 1'b0);
    finish_check(1'b0, '0);

    // Stray start at idx 7 with a different key
    load_q();
    start_key(rk[10]);
    drain(-1, 7, 128'h00112233445566778899aabbccddeeff, -1, 1'b0);
    finish_check(1'b0, '0);

    // Reset at idx 6, then a fresh run
    load_q();
    start_key(rk[10]);
    drain(-1, -1, '0, 6, 1'b0);
    load_q();
    start_key(rk[10]);
    drain(-1, -1, '0, -1, 1'b0);
    finish_check(1'b0, '0);

    // start in the done cycle is ignored; the next one is accepted
    load_q();
    start_key(rk[10]);
    drain(-1, -1, '0, -1, 1'b0);
    finish_check(1'b1, 128'hffeeddccbbaa99887766554433221100);
    load_q();
    start_key(rk[10]);
    drain(-1, -1, '0, -1, 1'b0);
    finish_check(1'b0, '0);

    // Random keys with random backpressure
    for (int n = 0; n < 200; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      expand(k);
      load_q();
      start_key(rk[10]);
      drain(-1, -1, '0, -1, 1'b1);
      finish_check(1'b0, '0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
